// File: rtl/fp_exc_classify_if.sv
// Handshake bundle for fp_exc_classify: operand-pair input port and classification result port.
interface fp_exc_classify_if #(parameter int WIDTH = 32);
  // Each port transfers on a rising edge where valid and ready are both high; the source keeps
  // valid and its payload unchanged until that transfer, while ready may change at any time.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       exception_flag;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-2:0] copied_operand;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_sub_q;

  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, exception_flag, sign_a, sign_b, copied_operand, a_q, b_q, op_sub_q
  );

  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, exception_flag, sign_a, sign_b, copied_operand, a_q, b_q, op_sub_q
  );
endinterface

// File: rtl/fp_exc_classify.sv
// Two-stage IEEE-754 single add/sub special-case classifier with valid/ready flow control.
// Optional FP_EXC_STATS_EN adds a saturating count of delivered non-NONE results (exc_count).
module fp_exc_classify #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  fp_exc_classify_if.slave bus
`ifdef FP_EXC_STATS_EN
  ,
  output logic [15:0]      exc_count
`endif
);
  typedef enum logic [2:0] {
    EXC_NONE          = 3'b000,
    EXC_NAN           = 3'b001,
    EXC_COPY_A        = 3'b010,
    EXC_COPY_B        = 3'b011,
    EXC_FIN_MIN_INF   = 3'b100,
    EXC_ZERO_MIN_ZERO = 3'b101,
    EXC_ZERO_MIN_SOME = 3'b110,
    EXC_SUB_SAME_VAL  = 3'b111
  } exc_e;

  // Class vector layout: {nan, inf, zero}
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s1_op_q, s1_op_d;
  logic [2:0]       s1_ca_q, s1_ca_d, s1_cb_q, s1_cb_d;

  logic             out_valid_q, out_valid_d;
  exc_e             flag_q, flag_d;
  logic [WIDTH-2:0] copied_q, copied_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0] res_a_q, res_a_d, res_b_q, res_b_d;
  logic             res_op_q, res_op_d;

  logic             s2_free, s1_adv, in_ready, accept;
  logic             eff_sign_b;
  exc_e             flag_c;
  logic [WIDTH-2:0] copied_c;

  function automatic logic [2:0] classify(input logic [WIDTH-1:0] x);
    logic exp_ones, exp_zero, mant_zero;
    exp_ones  = &x[WIDTH-2:WIDTH-9];
    exp_zero  = ~|x[WIDTH-2:WIDTH-9];
    mant_zero = ~|x[WIDTH-10:0];
    return {exp_ones & ~mant_zero, exp_ones & mant_zero, exp_zero & mant_zero};
  endfunction

  always_comb begin
    s2_free  = !out_valid_q || bus.out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s1_adv;
    accept   = bus.in_valid && in_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_ca_d    = s1_ca_q;
    s1_cb_d    = s1_cb_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = bus.a;
      s1_b_d     = bus.b;
      s1_op_d    = bus.op_sub;
      s1_ca_d    = classify(bus.a);
      s1_cb_d    = classify(bus.b);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // First matching rule wins; B's sign is taken after applying the operation.
  always_comb begin
    eff_sign_b = s1_b_q[WIDTH-1] ^ s1_op_q;
    flag_c     = EXC_NONE;
    if (s1_ca_q[2] || s1_cb_q[2]) begin
      flag_c = EXC_NAN;
    end else if (s1_ca_q[1] && s1_cb_q[1]) begin
      flag_c = (s1_a_q[WIDTH-1] != eff_sign_b) ? EXC_NAN :
               (s1_op_q ? EXC_COPY_A : EXC_SUB_SAME_VAL);
    end else if (s1_ca_q[1]) begin
      flag_c = EXC_COPY_A;
    end else if (s1_cb_q[1]) begin
      flag_c = s1_op_q ? EXC_FIN_MIN_INF : EXC_COPY_B;
    end else if (s1_ca_q[0] && s1_cb_q[0]) begin
      flag_c = EXC_ZERO_MIN_ZERO;
    end else if (s1_cb_q[0]) begin
      flag_c = EXC_COPY_A;
    end else if (s1_ca_q[0]) begin
      flag_c = s1_op_q ? EXC_ZERO_MIN_SOME : EXC_COPY_B;
    end
    copied_c = '0;
    case (flag_c)
      EXC_COPY_A, EXC_SUB_SAME_VAL:  copied_c = s1_a_q[WIDTH-2:0];
      EXC_COPY_B, EXC_ZERO_MIN_SOME: copied_c = s1_b_q[WIDTH-2:0];
      default:                       copied_c = '0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    flag_d      = flag_q;
    copied_d    = copied_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    res_op_d    = res_op_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      flag_d      = flag_c;
      copied_d    = copied_c;
      sign_a_d    = s1_a_q[WIDTH-1];
      sign_b_d    = s1_b_q[WIDTH-1];
      res_a_d     = s1_a_q;
      res_b_d     = s1_b_q;
      res_op_d    = s1_op_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= 1'b0;
      s1_ca_q     <= '0;
      s1_cb_q     <= '0;
      out_valid_q <= 1'b0;
      flag_q      <= EXC_NONE;
      copied_q    <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_op_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_ca_q     <= s1_ca_d;
      s1_cb_q     <= s1_cb_d;
      out_valid_q <= out_valid_d;
      flag_q      <= flag_d;
      copied_q    <= copied_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_op_q    <= res_op_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.exception_flag = flag_q;
  assign bus.copied_operand = copied_q;
  assign bus.sign_a         = sign_a_q;
  assign bus.sign_b         = sign_b_q;
  assign bus.a_q            = res_a_q;
  assign bus.b_q            = res_b_q;
  assign bus.op_sub_q       = res_op_q;

`ifdef FP_EXC_STATS_EN
  logic [15:0] exc_count_q, exc_count_d;

  always_comb begin
    exc_count_d = exc_count_q;
    if (out_valid_q && bus.out_ready && (flag_q != EXC_NONE) && (exc_count_q != 16'hFFFF)) begin
      exc_count_d = exc_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count_q <= '0;
    end else begin
      exc_count_q <= exc_count_d;
    end
  end

  assign exc_count = exc_count_q;
`endif
endmodule

// File: doc/fp_exc_classify.md
FP_EXC_CLASSIFY -- requirements
Module: fp_exc_classify

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; only 32 (IEEE-754 single) supported.
REQ-002 SHALL have ports, one per line:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op_sub  input  1  1 = A-B, 0 = A+B.
- out_valid  output  1  classification result present.
- out_ready  input  1  consumer accepts result.
- exception_flag  output  3  special-case code.
- sign_a  output  1  sign bit of A.
- sign_b  output  1  raw sign bit of B (not effective).
- copied_operand  output  WIDTH-1  magnitude bits for copy cases.
- a_q, b_q  output  WIDTH  operands aligned with result.
- op_sub_q  output  1  op aligned with result.

Function
REQ-003 SHALL encode exception_flag: 000 NONE, 001 NAN, 010 COPY_A, 011 COPY_B, 100 FIN_MIN_INF, 101 ZERO_MIN_ZERO, 110 ZERO_MIN_SOME, 111 SUB_SAME_VAL.
REQ-004 SHALL classify each operand: NaN = exp FF, mant != 0; Inf = exp FF, mant 0; Zero = exp 00, mant 0; all else (incl. subnormal) finite nonzero.
REQ-005 SHALL take effective sign of B as sign_b XOR op_sub.
REQ-006 SHALL apply first-match priority:
- (1) A or B NaN -> 001.
- (2) both Inf, effective signs differ -> 001.
- (3) both Inf, signs equal -> 111 if add, 010 if sub.
- (4) A Inf -> 010.
- (5) B Inf -> 011 if add, 100 if sub.
- (6) both Zero -> 101.
- (7) B Zero -> 010.
- (8) A Zero -> 011 if add, 110 if sub.
- (9) else 000.
REQ-007 SHALL drive copied_operand = a[30:0] for 010 and 111, b[30:0] for 011 and 110, zero otherwise.
REQ-008 SHALL be a two-stage pipeline: stage 1 registers operands and class bits; stage 2 registers flag, copied_operand and pass-through fields.
REQ-009 SHALL give latency 2 cycles from accepted input to out_valid when out_ready is held high; throughput 1 per cycle.
REQ-010 SHALL transfer on valid & ready at both ports; a stage advances only when the next stage is empty or advancing.
REQ-011 SHALL drive in_ready = !stage1_valid | stage1_advance.
REQ-012 SHALL hold all output fields stable while out_valid & !out_ready.
REQ-013 SHALL lose and duplicate no pair: results are delivered in acceptance order under arbitrary out_ready patterns.
REQ-014 SHALL accept a new pair and emit the final result in the same cycle while full with out_ready=1.

Reset
REQ-015 SHALL, while rst=1 at a clock edge, clear both stage valids, out_valid=0, exception_flag=000, copied_operand=0, sign_a=sign_b=0, a_q=b_q=0, op_sub_q=0.
REQ-016 SHALL discard in-flight pairs on reset mid-operation; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-017 SHALL, with macro FP_EXC_STATS_EN defined, add output exc_count (16 bits): counts delivered results with flag != 000, saturates at FFFF, cleared by rst.
REQ-018 SHALL, without FP_EXC_STATS_EN, omit exc_count and its logic entirely; all other behaviour is identical.

Verification
REQ-019 SHALL cover: a=7FC00000, b=3F800000, add -> flag 001 two cycles after accept.
REQ-020 SHALL cover: a=7F800000, b=7F800000, sub -> 001; same pair with add -> 111, copied_operand=7F800000.
REQ-021 SHALL cover: a=3F800000, b=FF800000, sub -> 100, sign_b=1; same pair with add -> 011.
REQ-022 SHALL cover: a=00000000, b=40000000, sub -> 110, copied_operand=40000000; a=80000000, b=80000000, add -> 101.
REQ-023 SHALL cover: 8 back-to-back pairs with out_ready toggled 1,0,0,1,... -> all 8 results in order, fields stable while stalled, in_ready low when both stages are full and stalled.
REQ-024 SHALL cover: rst asserted with 2 pairs in flight -> out_valid=0 next cycle, no stale result emitted; with FP_EXC_STATS_EN, exc_count=0.
